// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the RAM arbiter and a synchronous RAM.
// The master side drives requests and RAM read data; the slave side is the arbiter.
interface ram_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [15:0] rdata;
    logic [7:0]  ram_addr;
    logic        ram_w_en;
    logic [15:0] ram_w_data;
    logic [15:0] ram_r_data;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_r_data,
        input  gnt0, gnt1, done0, done1, rdata, ram_addr, ram_w_en, ram_w_data
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_r_data,
        output gnt0, gnt1, done0, done1, rdata, ram_addr, ram_w_en, ram_w_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Each access takes an ISSUE cycle (gnt, RAM driven) and a DONE cycle (done, read data).
module ram_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_any_req;
    logic        w_accept;
    logic        w_winner;
    logic        w_we;
    logic [7:0]  w_addr;
    logic [15:0] w_wdata;

    logic        r_last;
    logic        r_winner;
    logic        r_we;
    logic [7:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic        r_ram_w_en;
    logic        w_rd_done;

    assign w_any_req = bus.req0 | bus.req1;

    // Round-robin winner selection and mux of the winner's request fields
    always_comb begin
        w_winner = 1'b0;
        w_we     = 1'b0;
        w_addr   = 8'h00;
        w_wdata  = 16'h0000;
        if (bus.req0 && bus.req1) begin
            w_winner = ~r_last;
        end else if (bus.req1) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
        if (w_winner) begin
            w_we    = bus.we1;
            w_addr  = bus.addr1;
            w_wdata = bus.wdata1;
        end else begin
            w_we    = bus.we0;
            w_addr  = bus.addr0;
            w_wdata = bus.wdata0;
        end
    end

    // Next-state logic; requests are only looked at in IDLE and DONE
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ISSUE;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_accept    = 1'b0;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_DONE;
                w_accept    = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_accept    = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake pulses and RAM write enable; an access aborted by reset never reaches done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_ram_w_en <= 1'b0;
        end else begin
            r_gnt0     <= w_accept & ~w_winner;
            r_gnt1     <= w_accept &  w_winner;
            r_done0    <= (r_state == ST_ISSUE) & ~r_winner;
            r_done1    <= (r_state == ST_ISSUE) &  r_winner;
            r_ram_w_en <= w_accept & w_we;
        end
    end

    // Latched request and last-served pointer, both updated on every accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_winner <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 8'h00;
            r_wdata  <= 16'h0000;
        end else if (w_accept) begin
            r_last   <= w_winner;
            r_winner <= w_winner;
            r_we     <= w_we;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
        end else begin
            r_last   <= r_last;
            r_winner <= r_winner;
            r_we     <= r_we;
            r_addr   <= r_addr;
            r_wdata  <= r_wdata;
        end
    end

    // RAM data only becomes valid in DONE, so it is forwarded then and held from here on
    assign w_rd_done = (r_state == ST_DONE) & ~r_we;

    // Read data hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 16'h0000;
        end else if (w_rd_done) begin
            r_rdata <= bus.ram_r_data;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign bus.gnt0       = r_gnt0;
    assign bus.gnt1       = r_gnt1;
    assign bus.done0      = r_done0;
    assign bus.done1      = r_done1;
    assign bus.rdata      = w_rd_done ? bus.ram_r_data : r_rdata;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_w_en   = r_ram_w_en;
    assign bus.ram_w_data = r_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: synchronous RAM model, slot-based reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_ram_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   chk_en;

    logic [15:0] mem     [256];
    logic [15:0] exp_mem [256];

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        if (a == 16'h0010) return 16'h1234;
        if (a == 16'h0030) return 16'h5A5A;
        return {8'hA5, a[7:0]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM: read-before-write, data valid the cycle after the address edge
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        bus.ram_r_data = 16'h0000;
        forever begin
            @(posedge clk);
            bus.ram_r_data <= mem[bus.ram_addr];
            if (bus.ram_w_en === 1'b1) mem[bus.ram_addr] = bus.ram_w_data;
        end
    end

    // Reference model: an access may start on any edge that does not end a grant cycle;
    // it grants in the next cycle and completes (memory effect, done, rdata) in the one after.
    logic        m_gnt0 = 1'b0, m_gnt1 = 1'b0, m_done0 = 1'b0, m_done1 = 1'b0, m_wen = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_wdata = 16'h0000, m_rdata = 16'h0000;
    logic        m_last = 1'b1;
    bit          p_valid = 1'b0, p_who, p_we;
    logic [7:0]  p_addr;
    logic [15:0] p_wdata;

    initial begin
        bit prev_issue;
        bit who;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_done0 = 1'b0; m_done1 = 1'b0; m_wen = 1'b0;
                m_addr = 8'h00; m_wdata = 16'h0000; m_rdata = 16'h0000;
                m_last = 1'b1; p_valid = 1'b0;
            end else begin
                prev_issue = m_gnt0 | m_gnt1;
                m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_done0 = 1'b0; m_done1 = 1'b0; m_wen = 1'b0;
                if (p_valid) begin
                    if (p_who) m_done1 = 1'b1; else m_done0 = 1'b1;
                    if (p_we) exp_mem[p_addr] = p_wdata; else m_rdata = exp_mem[p_addr];
                    p_valid = 1'b0;
                end
                if (!prev_issue && (bus.req0 || bus.req1)) begin
                    who    = (bus.req0 && bus.req1) ? !m_last : bus.req1;
                    m_last = who;
                    p_who  = who;
                    p_we   = who ? bus.we1    : bus.we0;
                    p_addr = who ? bus.addr1  : bus.addr0;
                    p_wdata = who ? bus.wdata1 : bus.wdata0;
                    p_valid = 1'b1;
                    m_gnt0  = !who;
                    m_gnt1  = who;
                    m_wen   = p_we;
                    m_addr  = p_addr;
                    m_wdata = p_wdata;
                end
            end
        end
    end

    // Per-cycle comparison against the reference model
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_gnt0",  {15'd0, bus.gnt0},  {15'd0, m_gnt0});
            check("m_gnt1",  {15'd0, bus.gnt1},  {15'd0, m_gnt1});
            check("m_done0", {15'd0, bus.done0}, {15'd0, m_done0});
            check("m_done1", {15'd0, bus.done1}, {15'd0, m_done1});
            check("m_wen",   {15'd0, bus.ram_w_en}, {15'd0, m_wen});
            check("m_addr",  {8'd0, bus.ram_addr}, {8'd0, m_addr});
            check("m_wdata", bus.ram_w_data, m_wdata);
            check("m_rdata", bus.rdata, m_rdata);
            check("one_hot", {14'd0, bus.gnt0 & bus.gnt1, bus.done0 & bus.done1}, 16'h0000);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        chk_en = 1'b0;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 16'h0000; bus.wdata1 = 16'h0000;
        step();
        chk_en = 1'b1;
        step();
        check("rst_gnt0", {15'd0, bus.gnt0}, 16'h0000);
        check("rst_wen", {15'd0, bus.ram_w_en}, 16'h0000);
        check("rst_rdata", bus.rdata, 16'h0000);
        check("rst_addr", {8'd0, bus.ram_addr}, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_wen", {15'd0, bus.ram_w_en}, 16'h0000);
            check("idle_gnt0", {15'd0, bus.gnt0}, 16'h0000);
        end

        // Single read of 0x10
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        step();
        check("rd_gnt0", {15'd0, bus.gnt0}, 16'h0001);
        check("rd_addr", {8'd0, bus.ram_addr}, 16'h0010);
        check("rd_wen", {15'd0, bus.ram_w_en}, 16'h0000);
        bus.req0 = 1'b0;
        step();
        check("rd_done0", {15'd0, bus.done0}, 16'h0001);
        check("rd_rdata", bus.rdata, 16'h1234);
        step();

        // Write 0xBEEF to 0x20 from requester 1, then read it back from requester 0
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 16'hBEEF;
        step();
        check("wr_gnt1", {15'd0, bus.gnt1}, 16'h0001);
        check("wr_wen_issue", {15'd0, bus.ram_w_en}, 16'h0001);
        bus.req1 = 1'b0;
        step();
        check("wr_done1", {15'd0, bus.done1}, 16'h0001);
        check("wr_wen_done", {15'd0, bus.ram_w_en}, 16'h0000);
        check("wr_rdata_held", bus.rdata, 16'h1234);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h20;
        step();
        check("rb_gnt0", {15'd0, bus.gnt0}, 16'h0001);
        bus.req0 = 1'b0;
        step();
        check("rb_done0", {15'd0, bus.done0}, 16'h0001);
        check("rb_rdata", bus.rdata, 16'hBEEF);
        step();

        // Reset during the ISSUE cycle of a write to 0x30
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h30; bus.wdata1 = 16'hDEAD;
        step();
        check("abort_gnt1", {15'd0, bus.gnt1}, 16'h0001);
        check("abort_wen_pre", {15'd0, bus.ram_w_en}, 16'h0001);
        bus.req1 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_wen", {15'd0, bus.ram_w_en}, 16'h0000);
        check("abort_gnt1_clr", {15'd0, bus.gnt1}, 16'h0000);
        check("abort_rdata", bus.rdata, 16'h0000);
        step();
        check("abort_done1", {15'd0, bus.done1}, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_wen", {15'd0, bus.ram_w_en}, 16'h0000);
            check("post_done1", {15'd0, bus.done1}, 16'h0000);
        end
        check("abort_mem", mem[8'h30], 16'h5A5A);

        // Contention from reset release: 0,1,0,1
        rst_n = 1'b0;
        bus.we0 = 1'b0; bus.we1 = 1'b0; bus.addr0 = 8'h10; bus.addr1 = 8'h20;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("rr_gnt0", {15'd0, bus.gnt0}, (i % 4 == 1) ? 16'h0001 : 16'h0000);
            check("rr_gnt1", {15'd0, bus.gnt1}, (i % 4 == 3) ? 16'h0001 : 16'h0000);
            if (i == 8) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        step();
        check("rr_quiet", {15'd0, bus.gnt0 | bus.gnt1}, 16'h0000);
        step();

        // Streaming reads of 0x00..0x03 from requester 0
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            step();
            check("st_gnt0", {15'd0, bus.gnt0}, ((i % 2 == 1) && i <= 7) ? 16'h0001 : 16'h0000);
            check("st_done0", {15'd0, bus.done0}, ((i % 2 == 0) && i <= 8) ? 16'h0001 : 16'h0000);
            if ((i % 2 == 0) && i <= 8)
                check("st_rdata", bus.rdata, 16'hA500 + 16'(i / 2 - 1));
            if (i == 7) bus.req0 = 1'b0;
            else if (i % 2 == 1) bus.addr0 = 8'((i + 1) / 2);
        end
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 req0 / req1  input  1 each  access request, requester 0 (CPU core) / requester 1 (loader).
REQ-004 we0 / we1  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-005 addr0 / addr1  input  8 each  RAM word address.
REQ-006 wdata0 / wdata1  input  16 each  write data.
REQ-007 gnt0 / gnt1  output  1 each  registered one-cycle pulse; the request has been accepted.
REQ-008 done0 / done1  output  1 each  registered one-cycle pulse; the access has completed.
REQ-009 rdata  output  16  read data; valid when done0 or done1 is high after a read; held otherwise.
REQ-010 ram_addr  output  8  RAM address.
REQ-011 ram_w_en  output  1  RAM write enable.
REQ-012 ram_w_data  output  16  RAM write data.
REQ-013 ram_r_data  input  16  RAM read data; synchronous RAM, valid the cycle after the address edge.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE and DONE.
REQ-015 req0 and req1 SHALL be sampled only in IDLE and DONE.
REQ-016 IDLE/DONE with any req high -> ISSUE; the winner's we, addr and wdata are latched and its gnt asserts during ISSUE.
REQ-017 IDLE with no req -> IDLE; DONE with no req -> IDLE.
REQ-018 ISSUE -> DONE unconditionally; ram_addr and ram_w_data are driven from latched values, and ram_w_en = latched we.
REQ-019 DONE: winner's done pulses; rdata = ram_r_data if the access was a read, else rdata is unchanged.
REQ-020 ram_w_en SHALL be 0 in IDLE and DONE; ram_addr and ram_w_data hold their last values there.
REQ-021 Arbitration SHALL be round-robin with a 1-bit last-served register.
REQ-022 If both req are high, the requester that is not last-served wins; a single requester wins alone.
REQ-023 last-served updates on every entry to ISSUE.
REQ-024 Latency: req high in IDLE cycle T -> gnt at T+1 and done at T+2.
REQ-025 Back-to-back accesses (DONE -> ISSUE) give one access every 2 cycles.
REQ-026 Requester handshake: hold req, we, addr and wdata stable until gnt is seen.
REQ-027 A requester that wants no further access SHALL drop req in the gnt cycle; req still high in DONE is a new request.
REQ-028 At most one gnt and at most one done SHALL be high in any cycle.
REQ-029 gnt and done of the same requester are never high together.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, gnt0/1=0, done0/1=0, rdata=0, ram_addr=0, ram_w_en=0, ram_w_data=0, last-served=1, latched request=0.
REQ-031 With last-served=1 after reset, requester 0 wins the first tie.
REQ-032 Reset during ISSUE SHALL drop ram_w_en immediately; the aborted access produces no done, and after release the arbiter returns to IDLE.

Verification
REQ-033 Reset: rst_n=0 in mid-traffic -> all outputs 0 in the same cycle; after release with req0=req1=0, the block stays IDLE with ram_w_en=0.
REQ-034 Single read: mem[0x10]=0x1234, req0=1, we0=0, addr0=0x10 at T -> gnt0 at T+1 with ram_addr=0x10 and ram_w_en=0; done0=1 and rdata=0x1234 at T+2.
REQ-035 Write then read: req1 writes 0xBEEF to 0x20 -> ram_w_en=1 only in the ISSUE cycle; req0 then reads 0x20 -> rdata=0xBEEF with done0.
REQ-036 Contention: req0 and req1 both held high from reset release -> grant order 0,1,0,1 with gnt every 2 cycles; no gnt overlap.
REQ-037 Reset mid-write: rst_n low during ISSUE of a req1 write to 0x30 -> ram_w_en falls immediately, no done1 pulse, and mem[0x30] is unchanged.
REQ-038 Streaming: req0 held alone, addr0 stepping 0x00..0x03 on each gnt -> 4 accesses with done0 at T+2, T+4, T+6, T+8.
